// File: rtl/mips_multicycle_ctrl_if.sv
// Datapath-facing bus of the multi-cycle MIPS control FSM.
// master = controller side, slave = datapath/memory side.
interface mips_multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic             run_i;
    logic [5:0]       opcode_i;
    logic             mem_ready_i;
    logic             pc_write_o;
    logic             pc_write_cond_o;
    logic             i_or_d_o;
    logic             mem_read_o;
    logic             mem_write_o;
    logic             ir_write_o;
    logic             mem_to_reg_o;
    logic             reg_dst_o;
    logic             reg_write_o;
    logic             alu_src_a_o;
    logic [1:0]       alu_src_b_o;
    logic [1:0]       pc_source_o;
    logic [2:0]       alu_op_o;
    logic             busy_o;
    logic             trap_o;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] instr_count_o;

    modport master (
        input  run_i, opcode_i, mem_ready_i,
        output pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
               mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, pc_source_o,
               alu_op_o, busy_o, trap_o, state_o, instr_count_o
    );

    modport slave (
        output run_i, opcode_i, mem_ready_i,
        input  pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
               mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, pc_source_o,
               alu_op_o, busy_o, trap_o, state_o, instr_count_o
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with retired-instruction counter.
// Define CTRL_ILLEGAL_TRAP_EN to trap on illegal opcodes (default: treat them as NOPs).
module mips_multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input logic                    clk,
    input logic                    reset,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAddr  = 4'd3,
        StMemRead  = 4'd4,
        StMemWb    = 4'd5,
        StMemWrite = 4'd6,
        StExecute  = 4'd7,
        StRWb      = 4'd8,
        StBranch   = 4'd9,
        StJump     = 4'd10,
        StIExec    = 4'd11,
        StIWb      = 4'd12,
        StTrap     = 4'd13
    } state_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpOri   = 6'b001101;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           next_instr;
    logic             retire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // run_i is only looked at on an instruction's final cycle.
    assign next_instr = bus.run_i ? StFetch : StIdle;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            StIdle:  if (bus.run_i) state_d = StFetch;
            StFetch: if (bus.mem_ready_i) state_d = StDecode;
            StDecode: begin
                case (bus.opcode_i)
                    OpRType:      state_d = StExecute;
                    OpLw, OpSw:   state_d = StMemAddr;
                    OpBeq:        state_d = StBranch;
                    OpJ:          state_d = StJump;
                    OpAddi, OpOri: state_d = StIExec;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:      state_d = StTrap;
`else
                    default:      state_d = next_instr;
`endif
                endcase
            end
            StMemAddr: state_d = (bus.opcode_i == OpSw) ? StMemWrite : StMemRead;
            StMemRead: if (bus.mem_ready_i) state_d = StMemWb;
            StMemWrite: begin
                if (bus.mem_ready_i) begin
                    state_d = next_instr;
                    retire  = 1'b1;
                end
            end
            StExecute: state_d = StRWb;
            StIExec:   state_d = StIWb;
            StMemWb, StRWb, StBranch, StJump, StIWb: begin
                state_d = next_instr;
                retire  = 1'b1;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StIdle;
        endcase
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_comb begin
        bus.pc_write_o      = 1'b0;
        bus.pc_write_cond_o = 1'b0;
        bus.i_or_d_o        = 1'b0;
        bus.mem_read_o      = 1'b0;
        bus.mem_write_o     = 1'b0;
        bus.ir_write_o      = 1'b0;
        bus.mem_to_reg_o    = 1'b0;
        bus.reg_dst_o       = 1'b0;
        bus.reg_write_o     = 1'b0;
        bus.alu_src_a_o     = 1'b0;
        bus.alu_src_b_o     = 2'b00;
        bus.pc_source_o     = 2'b00;
        bus.alu_op_o        = 3'b000;
        bus.busy_o          = (state_q != StIdle);
        bus.trap_o          = 1'b0;
        bus.state_o         = state_q;
        case (state_q)
            StFetch: begin
                bus.mem_read_o  = 1'b1;
                bus.alu_src_b_o = 2'b01;
                bus.alu_op_o    = 3'b100;
                bus.ir_write_o  = bus.mem_ready_i;
                bus.pc_write_o  = bus.mem_ready_i;
            end
            StDecode: begin
                bus.alu_src_b_o = 2'b11;
                bus.alu_op_o    = 3'b100;
            end
            StMemAddr: begin
                bus.alu_src_a_o = 1'b1;
                bus.alu_src_b_o = 2'b10;
                bus.alu_op_o    = 3'b100;
            end
            StMemRead: begin
                bus.mem_read_o = 1'b1;
                bus.i_or_d_o   = 1'b1;
            end
            StMemWb: begin
                bus.mem_to_reg_o = 1'b1;
                bus.reg_write_o  = 1'b1;
            end
            StMemWrite: begin
                bus.mem_write_o = 1'b1;
                bus.i_or_d_o    = 1'b1;
            end
            StExecute: begin
                bus.alu_src_a_o = 1'b1;
                bus.alu_op_o    = 3'b111;
            end
            StRWb: begin
                bus.reg_dst_o   = 1'b1;
                bus.reg_write_o = 1'b1;
            end
            StBranch: begin
                bus.alu_src_a_o     = 1'b1;
                bus.alu_op_o        = 3'b110;
                bus.pc_write_cond_o = 1'b1;
                bus.pc_source_o     = 2'b01;
            end
            StJump: begin
                bus.pc_write_o  = 1'b1;
                bus.pc_source_o = 2'b10;
            end
            StIExec: begin
                bus.alu_src_a_o = 1'b1;
                bus.alu_src_b_o = 2'b10;
                bus.alu_op_o    = (bus.opcode_i == OpOri) ? 3'b101 : 3'b100;
            end
            StIWb: bus.reg_write_o = 1'b1;
            StTrap: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                bus.trap_o = 1'b1;
`endif
            end
            default: ;
        endcase
        // Belt and braces: never let a write strobe escape during reset.
        if (reset) begin
            bus.pc_write_o      = 1'b0;
            bus.pc_write_cond_o = 1'b0;
            bus.mem_write_o     = 1'b0;
            bus.ir_write_o      = 1'b0;
            bus.reg_write_o     = 1'b0;
        end
    end

    assign bus.instr_count_o = cnt_q;
endmodule
